decode_fetch_align_buffer: RTL and testbench

- Parametrised instruction buffer between the fetch interface and the decode stage.
- Accepts 32-bit fetch words, stores them as halfwords in a circular queue, and presents one aligned instruction per handshake: a 16-bit compressed instruction zero-extended, or a 32-bit instruction, including one spanning two fetch words.
- Generalises the decode front end: adds configurable depth, backpressure, misaligned-target handling after redirect, and per-halfword fetch-error tagging.

---
 rtl/decode_fetch_align_buffer.sv | 191 +++++++++++++++++++
 tb/tb_decode_fetch_align_buffer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_fetch_align_buffer.sv
// decode_fetch_align_buffer
//   Halfword circular queue between the 32-bit fetch interface and decode.
//   It presents one aligned instruction per handshake. A compressed
//   instruction is zero-extended to 32 bits. A 32-bit instruction may span
//   two fetch words and may wrap from the last entry to entry 0.
//   Each halfword carries its own fetch-fault tag.
//   Optional feature macro: DECODE_FETCH_ALIGN_BYPASS_EN. When defined, a
//   word pushed into an empty queue is presented in the same cycle.
module decode_fetch_align_buffer #(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [PC_WIDTH-1:0]         flush_pc,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 in_word,
    input  logic                        in_error,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_instr,
    output logic [PC_WIDTH-1:0]         out_pc,
    output logic [PC_WIDTH-1:0]         out_npc,
    output logic                        out_compressed,
    output logic                        out_error,
    output logic [$clog2(2*DEPTH):0]    count
);

    localparam int HCAP = 2 * DEPTH;
    localparam int PW   = $clog2(HCAP);
    localparam int CW   = PW + 1;
    localparam logic [CW-1:0] ACCEPT_LIMIT = CW'(HCAP - 2);
    localparam logic [31:0]   NOP_INSTR    = 32'h0000_0013;

    typedef enum logic {ST_RUN, ST_SKIP} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [15:0]           r_mem_hw  [0:HCAP-1];
    logic                  r_mem_err [0:HCAP-1];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_cnt;
    logic [PC_WIDTH-1:0]   r_pc;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_byp;
    logic [15:0]           w_in_hw0;
    logic [15:0]           w_in_hw1;
    logic [1:0]            w_in_n;
    logic [15:0]           w_h0;
    logic [15:0]           w_h1;
    logic                  w_e0;
    logic                  w_e1;
    logic [CW-1:0]         w_avail;
    logic                  w_comp;
    logic [1:0]            w_pop_n;
    logic [1:0]            w_skip_n;
    logic [1:0]            w_wr_n;
    logic [1:0]            w_head_adv;
    logic [PC_WIDTH-1:0]   w_pc_inc;
    logic [PW-1:0]         w_head_p1;
    logic [PW-1:0]         w_tail_p1;

    assign in_ready  = (r_cnt <= ACCEPT_LIMIT) && !flush;
    assign w_push    = in_valid && in_ready;
    assign w_head_p1 = r_head + PW'(1);
    assign w_tail_p1 = r_tail + PW'(1);
    assign count     = r_cnt;

`ifdef DECODE_FETCH_ALIGN_BYPASS_EN
    // A push into an empty queue is presented directly from the input.
    assign w_byp = w_push && (r_cnt == '0);
`else
    assign w_byp = 1'b0;
`endif

    // Normalise the incoming word: after a redirect to an odd halfword,
    // only the upper halfword belongs to the new instruction stream.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_in_hw0 = in_word[15:0];
        w_in_hw1 = in_word[31:16];
        w_in_n   = 2'd2;
        if (r_state == ST_SKIP) begin
            w_in_hw0 = in_word[31:16];
            w_in_n   = 2'd1;
        end
    end

    // Select the head view (stored entries, or the input word on bypass) and decode its length.
    always_comb begin
        w_h0    = r_mem_hw[r_head];
        w_e0    = r_mem_err[r_head];
        w_h1    = r_mem_hw[w_head_p1];
        w_e1    = r_mem_err[w_head_p1];
        w_avail = r_cnt;
        if (w_byp) begin
            w_h0    = w_in_hw0;
            w_e0    = in_error;
            w_h1    = w_in_hw1;
            w_e1    = in_error;
            w_avail = CW'(w_in_n);
        end
        w_comp = (w_h0[1:0] != 2'b11);
    end

    // Drive the decode-side outputs and work out how far each pointer moves.
    always_comb begin
        out_valid      = ((w_avail >= CW'(1)) && w_comp) || (w_avail >= CW'(2));
        out_compressed = out_valid && w_comp;
        out_instr      = NOP_INSTR;
        out_error      = 1'b0;
        if (out_valid) begin
            out_instr = w_comp ? {16'h0000, w_h0} : {w_h1, w_h0};
            out_error = w_e0 || (!w_comp && w_e1);
        end
        w_pc_inc   = out_compressed ? PC_WIDTH'(2) : PC_WIDTH'(4);
        out_pc     = r_pc;
        out_npc    = r_pc + w_pc_inc;
        w_pop      = out_valid && out_ready && !flush;
        w_pop_n    = w_pop ? (w_comp ? 2'd1 : 2'd2) : 2'd0;
        w_skip_n   = w_byp ? w_pop_n : 2'd0;
        w_wr_n     = w_push ? (w_in_n - w_skip_n) : 2'd0;
        w_head_adv = w_byp ? 2'd0 : w_pop_n;
    end

    // Write the halfwords of a push that were not consumed in the same cycle.
    // NOTE: the queue storage has no reset; r_cnt alone decides which entries are meaningful.
    always_ff @(posedge clock) begin
        if (w_push) begin
            if (w_skip_n == 2'd0) begin
                r_mem_hw[r_tail]  <= w_in_hw0;
                r_mem_err[r_tail] <= in_error;
                if (w_in_n == 2'd2) begin
                    r_mem_hw[w_tail_p1]  <= w_in_hw1;
                    r_mem_err[w_tail_p1] <= in_error;
                end
            end else if ((w_skip_n == 2'd1) && (w_in_n == 2'd2)) begin
                r_mem_hw[r_tail]  <= w_in_hw1;
                r_mem_err[r_tail] <= in_error;
            end
        end
    end

    // Pointer, occupancy and head-PC registers; reset beats flush, flush beats push/pop.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
            r_pc   <= '0;
        end else if (flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
            r_pc   <= flush_pc & ~PC_WIDTH'(1);
        end else begin
            r_head <= r_head + PW'(w_head_adv);
            r_tail <= r_tail + PW'(w_wr_n);
            r_cnt  <= r_cnt + CW'(w_wr_n) - CW'(w_head_adv);
            if (w_pop) begin
                r_pc <= r_pc + w_pc_inc;
            end
        end
    end

    // Alignment state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Alignment next state: an odd redirect target skips the low halfword of the next pushed word.
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = flush_pc[1] ? ST_SKIP : ST_RUN;
        end else if ((r_state == ST_SKIP) && w_push) begin
            w_state_next = ST_RUN;
        end
    end

endmodule

// File: tb/tb_decode_fetch_align_buffer.sv
// tb_decode_fetch_align_buffer
//   Scoreboard bench for decode_fetch_align_buffer (default build, DEPTH=4).
//   The stimulus process turns each accepted fetch word into halfwords and
//   parses them into expected instructions with plain queue arithmetic.
//   The monitor pops the expected queue whenever the DUT completes a handshake.
module tb_decode_fetch_align_buffer;

    localparam int DEPTH = 4;
    localparam int HCAP  = 2 * DEPTH;
    localparam int PCW   = 32;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        comp;
        logic        err;
        int          vis;
    } exp_t;

    typedef struct {
        logic [15:0] hw;
        logic        err;
    } hw_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic [PCW-1:0]    flush_pc = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_word = '0;
    logic              in_error = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_instr;
    logic [PCW-1:0]    out_pc;
    logic [PCW-1:0]    out_npc;
    logic              out_compressed;
    logic              out_error;
    logic [$clog2(HCAP):0] count;

    exp_t        exp_q[$];
    hw_t         pend[$];
    int          m_cnt = 0;
    logic [31:0] p_pc = '0;
    logic        m_skip = 1'b0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    decode_fetch_align_buffer #(.DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (
        .clock(clock), .reset(reset), .flush(flush), .flush_pc(flush_pc),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_error(in_error),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_npc(out_npc), .out_compressed(out_compressed),
        .out_error(out_error), .count(count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Split the pending halfword stream into whole instructions.
    task automatic parse();
        exp_t e;
        while (pend.size() > 0) begin
            if (pend[0].hw[1:0] != 2'b11) begin
                e.instr = {16'h0000, pend[0].hw};
                e.err   = pend[0].err;
                e.comp  = 1'b1;
                void'(pend.pop_front());
            end else if (pend.size() >= 2) begin
                e.instr = {pend[1].hw, pend[0].hw};
                e.err   = pend[0].err | pend[1].err;
                e.comp  = 1'b0;
                void'(pend.pop_front());
                void'(pend.pop_front());
            end else begin
                break;
            end
            e.pc  = p_pc;
            e.npc = p_pc + (e.comp ? 32'd2 : 32'd4);
            e.vis = cyc + 1;
            p_pc  = e.npc;
            exp_q.push_back(e);
        end
    endtask

    task automatic clear_model(input logic [31:0] pc, input logic skip);
        exp_q.delete();
        pend.delete();
        m_cnt  = 0;
        p_pc   = pc;
        m_skip = skip;
    endtask

    // One clock cycle of stimulus; entered and left 1 time unit after a rising edge.
    task automatic step(input logic v, input logic [31:0] w, input logic e,
                        input logic rdy, input logic fl, input logic [31:0] fpc);
        logic exp_rdy;
        hw_t  h;
        in_valid  = v;
        in_word   = w;
        in_error  = e;
        out_ready = rdy;
        flush     = fl;
        flush_pc  = fpc;
        #1;
        exp_rdy = (m_cnt <= HCAP - 2) && !fl;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("count", 64'(count), 64'(m_cnt));
        if (!fl && rdy && exp_q.size() > 0 && exp_q[0].vis <= cyc)
            m_cnt -= exp_q[0].comp ? 1 : 2;
        if (v && exp_rdy) begin
            h.err = e;
            if (!m_skip) begin
                h.hw = w[15:0];
                pend.push_back(h);
                m_cnt++;
            end
            h.hw = w[31:16];
            pend.push_back(h);
            m_cnt++;
            m_skip = 1'b0;
            parse();
        end
        @(posedge clock);
        #1;
        cyc++;
        if (fl) clear_model(fpc & 32'hFFFF_FFFE, fpc[1]);
    endtask

    task automatic do_reset();
        mon_en    = 1'b0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'h13);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_out_npc", 64'(out_npc), 64'd4);
        check("rst_out_compressed", 64'(out_compressed), 64'd0);
        check("rst_out_error", 64'(out_error), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        clear_model(32'd0, 1'b0);
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    // Monitor: mid-cycle, compare the head against the scoreboard and retire on handshake.
    always @(negedge clock) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].vis <= cyc) begin
                check("out_valid", 64'(out_valid), 64'd1);
                check("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
                check("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
                check("out_npc", 64'(out_npc), 64'(exp_q[0].npc));
                check("out_compressed", 64'(out_compressed), 64'(exp_q[0].comp));
                check("out_error", 64'(out_error), 64'(exp_q[0].err));
                if (out_ready && !flush) void'(exp_q.pop_front());
            end else begin
                check("idle_out_valid", 64'(out_valid), 64'd0);
                check("idle_out_instr", 64'(out_instr), 64'h13);
                check("idle_out_error", 64'(out_error), 64'd0);
            end
        end
    end

    initial begin
        logic [31:0] w;
        logic [15:0] lo;
        logic [15:0] hi;
        int          guard;

        do_reset();

        // Single 32-bit instruction, then two compressed in one word.
        step(1, 32'h00B50533, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 32'h45014501, 0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 1, 0, 0);

        // Spanning instruction across two words, leftover zero halfword.
        do_reset();
        step(1, 32'h05334501, 0, 0, 0, 0);
        step(1, 32'h000000B5, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 1, 0, 0);

        // Redirect to an odd halfword: only the upper half is kept.
        step(0, 0, 0, 0, 1, 32'h0000_1002);
        step(1, 32'h4501FFFF, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Fill to capacity with decode stalled, then stream through the wrap.
        do_reset();
        for (int i = 0; i < 6; i++) step(1, {16'(i + 16'h0100), 16'h0533}, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(1, {16'(i + 16'h0200), 16'h0533}, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++) step(1, {16'(i + 16'h0300), ((i % 3) == 0) ? 16'h4501 : 16'h0533}, 0, 1, 0, 0);
        repeat (8) step(0, 0, 0, 1, 0, 0);

        // Fault tagging: errored compressed half, errored low half of a spanning instruction.
        step(1, 32'h05334501, 1, 0, 0, 0);
        step(1, 32'h450100B5, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        // Flush coinciding with a push and a pop.
        step(1, 32'h00B50533, 0, 1, 1, 32'h0000_2000);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Randomised traffic, including redirects and one mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            lo = 16'($urandom);
            hi = 16'($urandom);
            if ($urandom_range(1, 0) == 1) lo[1:0] = 2'b11;
            if ($urandom_range(1, 0) == 1) hi[1:0] = 2'b11;
            w = {hi, lo};
            step($urandom_range(3, 0) != 0, w, $urandom_range(7, 0) == 0,
                 $urandom_range(2, 0) != 0, $urandom_range(29, 0) == 0,
                 $urandom);
        end

        // Drain everything still expected.
        guard = 0;
        while (exp_q.size() > 0 && guard < 64) begin
            step(0, 0, 0, 1, 0, 0);
            guard++;
        end
        check("drain_remaining", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
